// File: rtl/sal_rd_resp_buf_pkg.sv
// Shared DDR2 read-path constants and the read tag bundle.
package sal_rd_resp_buf_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 64;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [3:0]          len;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/sal_rd_resp_buf_if.sv
// Read command, DFI read data and AXI R channel bundle.
interface sal_rd_resp_buf_if #(
  parameter int ID_W   = sal_rd_resp_buf_pkg::AXI_ID_W,
  parameter int DATA_W = sal_rd_resp_buf_pkg::AXI_DATA_W
) ();

  logic              rd_cmd_valid_i;
  logic              rd_cmd_ready_o;
  logic [ID_W-1:0]   rd_cmd_id_i;
  logic [3:0]        rd_cmd_len_i;
  logic              dfi_rddata_valid_i;
  logic [DATA_W-1:0] dfi_rddata_i;
  logic              axi_rvalid_o;
  logic              axi_rready_i;
  logic [ID_W-1:0]   axi_rid_o;
  logic [DATA_W-1:0] axi_rdata_o;
  logic [1:0]        axi_rresp_o;
  logic              axi_rlast_o;
  logic              err_o;

  modport slave (
    input  rd_cmd_valid_i,
    input  rd_cmd_id_i,
    input  rd_cmd_len_i,
    input  dfi_rddata_valid_i,
    input  dfi_rddata_i,
    input  axi_rready_i,
    output rd_cmd_ready_o,
    output axi_rvalid_o,
    output axi_rid_o,
    output axi_rdata_o,
    output axi_rresp_o,
    output axi_rlast_o,
    output err_o
  );

  modport master (
    output rd_cmd_valid_i,
    output rd_cmd_id_i,
    output rd_cmd_len_i,
    output dfi_rddata_valid_i,
    output dfi_rddata_i,
    output axi_rready_i,
    input  rd_cmd_ready_o,
    input  axi_rvalid_o,
    input  axi_rid_o,
    input  axi_rdata_o,
    input  axi_rresp_o,
    input  axi_rlast_o,
    input  err_o
  );

endinterface

// File: rtl/sal_sync_fifo.sv
// Generic single-clock FIFO; push ignored when full, pop ignored when empty.
module sal_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;
  logic             rd_en;

  // full/empty come from the registered pointers, so a pop never
  // frees space for a push in the same cycle
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_rd_resp_buf.sv
// DFI read-return buffer: tags DFI beats with logged AXI ID/len, drives R.
module sal_rd_resp_buf
  import sal_rd_resp_buf_pkg::*;
#(
  parameter int ID_W       = AXI_ID_W,
  parameter int DATA_W     = AXI_DATA_W,
  parameter int CMD_DEPTH  = 8,
  parameter int DATA_DEPTH = 32
) (
  input logic              clk,
  input logic              rst,
  sal_rd_resp_buf_if.slave bus
);

  localparam int RW = $clog2(DATA_DEPTH) + 1;
  localparam int TW = $clog2(CMD_DEPTH) + 1;
  localparam logic [RW-1:0] DEPTH_V = RW'(DATA_DEPTH);

  rd_tag_t           tag_in;
  rd_tag_t           tag_head;
  logic              tag_full;
  logic              tag_empty;
  logic [TW-1:0]     tag_count;
  logic              data_full;
  logic              data_empty;
  logic [RW-1:0]     data_count;
  logic [DATA_W-1:0] data_head;
  logic [RW-1:0]     reserved;
  logic [RW-1:0]     need;
  logic [RW-1:0]     free;
  logic [3:0]        beat_cnt;
  logic              cmd_ready;
  logic              cmd_acc;
  logic              rvalid;
  logic              rlast;
  logic              r_hs;
  logic              r_last_hs;
  logic              err;
  logic              unused_cnt;

  assign tag_in.id  = bus.rd_cmd_id_i;
  assign tag_in.len = bus.rd_cmd_len_i;

  // slots are reserved at issue so DFI data, which cannot stall, always fits
  assign need      = RW'(bus.rd_cmd_len_i) + RW'(1);
  assign free      = DEPTH_V - reserved;
  assign cmd_ready = !tag_full && (free >= need);
  assign cmd_acc   = bus.rd_cmd_valid_i && cmd_ready;

  assign rvalid    = !data_empty && !tag_empty;
  assign rlast     = rvalid && (beat_cnt == tag_head.len);
  assign r_hs      = rvalid && bus.axi_rready_i;
  assign r_last_hs = r_hs && rlast;

  assign unused_cnt = ^{tag_count, data_count};

  sal_sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (CMD_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_acc),
    .din   (tag_in),
    .pop   (r_last_hs),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  sal_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.dfi_rddata_valid_i),
    .din   (bus.dfi_rddata_i),
    .pop   (r_hs),
    .dout  (data_head),
    .full  (data_full),
    .empty (data_empty),
    .count (data_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reserved <= '0;
    end else begin
      reserved <= reserved
                + (cmd_acc ? need : '0)
                - (r_hs ? RW'(1) : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (r_hs) begin
      beat_cnt <= rlast ? '0 : beat_cnt + 4'd1;
    end
  end

  // overflow drops the beat; orphan data is kept but flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bus.dfi_rddata_valid_i &&
                 (data_full || tag_empty)) begin
      err <= 1'b1;
    end
  end

  assign bus.rd_cmd_ready_o = cmd_ready;
  assign bus.axi_rvalid_o   = rvalid;
  assign bus.axi_rid_o      = tag_head.id;
  assign bus.axi_rdata_o    = data_head;
  assign bus.axi_rresp_o    = RRESP_OKAY;
  assign bus.axi_rlast_o    = rlast;
  assign bus.err_o          = err;

endmodule

// File: doc/sal_rd_resp_buf.md
Name: sal_rd_resp_buf

Overview:
- Read-return stage directly downstream of the DDR2 controller's DFI read interface.
- Captures DFI read data beats, which arrive in command order, and re-associates them with the AXI ID and burst length logged when the scheduler issued each read.
- Drives the AXI R channel with full backpressure support.
- Flow control is by slot reservation at command issue, so DFI data, which cannot be stalled, never overflows.

Parameters:
- ID_W, 4, AXI ID width
- DATA_W, 64, DFI/AXI read data width
- CMD_DEPTH, 8, outstanding-read tag FIFO depth (power of 2)
- DATA_DEPTH, 32, read data FIFO depth in beats (power of 2, >= 16)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rd_cmd_valid_i  in  1  scheduler is issuing a read burst
- rd_cmd_ready_o  out  1  buffer accepts the read; scheduler must not issue RD without it
- rd_cmd_id_i  in  ID_W  AXI ARID of the burst
- rd_cmd_len_i  in  4  AXI ARLEN (beats-1)
- dfi_rddata_valid_i  in  1  DFI read data beat valid
- dfi_rddata_i  in  DATA_W  DFI read data
- axi_rvalid_o  out  1  R valid
- axi_rready_i  in  1  R ready
- axi_rid_o  out  ID_W  RID
- axi_rdata_o  out  DATA_W  RDATA
- axi_rresp_o  out  2  RRESP, constant 2'b00
- axi_rlast_o  out  1  RLAST
- err_o  out  1  sticky protocol error

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. This is the single clock domain.
- Reset:
  - Both FIFOs are empty; reserved=0, beat_cnt=0, err_o=0.
  - axi_rvalid_o=0, axi_rlast_o=0.
  - rd_cmd_ready_o follows its equation and is 1 after reset.
  - Asserting rst mid-burst discards all buffered data and tags. No R beat appears until new commands arrive.
- Tag FIFO: CMD_DEPTH entries of {id, len}. It is pushed on rd_cmd_valid_i&&rd_cmd_ready_o. It is popped on the R handshake with axi_rlast_o=1.
- Data FIFO: DATA_DEPTH entries of DATA_W. It is pushed on dfi_rddata_valid_i and popped on the R handshake.
- Reservation counter `reserved`:
  - Width is log2(DATA_DEPTH)+1.
  - Each cycle: reserved += (cmd accept ? len+1 : 0) − (R handshake ? 1 : 0). Both terms apply in the same cycle.
  - Never exceeds DATA_DEPTH.
- rd_cmd_ready_o = !tag_full && (DATA_DEPTH − reserved) >= rd_cmd_len_i+1.
  - Combinational on rd_cmd_len_i, with no combinational path from rd_cmd_valid_i.
  - Freed space counts from the next cycle only; there is no same-cycle bypass.
- R channel:
  - axi_rvalid_o = !data_empty && !tag_empty.
  - rdata is the data FIFO head; rid is the tag head id.
  - axi_rlast_o = rvalid && (beat_cnt == head len).
  - beat_cnt increments on each handshake and clears to 0 on the last handshake.
  - All R outputs hold stable while rvalid && !rready.
- Latency: a DFI beat written in cycle N is visible on R in cycle N+1 at the earliest. There is no combinational DFI→R path.
- Simultaneous push and pop on either FIFO is permitted at any occupancy except push-when-full. Full is evaluated before the same-cycle pop.
- Errors (err_o set, stays high until rst):
  - dfi_rddata_valid_i while the data FIFO is full: the beat is dropped.
  - dfi_rddata_valid_i while the tag FIFO is empty (data without a command): the beat is stored. Its association is undefined.
- Zero-length bursts cannot occur; ARLEN=0 is a 1-beat burst with rlast on that beat.

Decomposition:
- Constants go in the shared DDR2 params header: DFI/AXI data width, ID width, and AXI RRESP_OKAY encoding.
- A packed typedef rd_tag_t {id, len} goes in the shared package.
- One generic sub-module, sal_sync_fifo (parameterised width/depth, full/empty/count, async active-high reset), is instantiated twice: tag FIFO and data FIFO.
- Control logic (reservation, beat counter, R mux, error) stays in sal_rd_resp_buf.

Test Plan:
- Single burst: cmd id=3 len=3, then 4 DFI beats 0xA0..0xA3 in cycles 5–8 with rready=1.
  - R beats appear in cycles 6–9 with rid=3 and data A0..A3.
  - rlast only on A3; reserved returns to 0.
- Backpressure: same burst with rready=0 for 10 cycles after the first rvalid.
  - rvalid, rdata=A0, rid and rlast=0 are held stable.
  - All 4 beats then drain in order.
- Reservation limit: DATA_DEPTH=32; issue two len=15 commands.
  - Ready drops for a third len=0 command.
  - It rises the cycle after the first R handshake completes.
- Interleaved IDs: cmds id=1 len=1, id=2 len=0, id=1 len=2; 6 beats B0..B5 back-to-back.
  - R sequence: (1,B0), (1,B1,last), (2,B2,last), (1,B3), (1,B4), (1,B5,last).
- Tag full: CMD_DEPTH=8; issue eight len=0 commands without data.
  - rd_cmd_ready_o=0 on the ninth command.
  - Ready returns after the first R handshake.
- Errors: DFI beat with no outstanding command → err_o=1 next cycle.
  - Apply rst mid-burst → err_o=0, rvalid=0, ready=1, and the FIFOs are empty.
